// File: rtl/barrel_pkg.sv
// barrel_pkg: shared types for the pipelined barrel shifter.
// Mode encoding and direction helper.
package barrel_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_SLL  = 3'd0,
    OP_SRL  = 3'd1,
    OP_SRA  = 3'd2,
    OP_ROL  = 3'd3,
    OP_ROR  = 3'd4,
    OP_PASS = 3'd5
  } op_e;

  function automatic logic is_right(op_e op);
    return op inside {OP_SRL, OP_SRA, OP_ROR};
  endfunction

endpackage

// File: rtl/barrel_shift_pipe_if.sv
// barrel_shift_pipe_if: input and output stream
// handshakes of the barrel shifter pipeline.
interface barrel_shift_pipe_if
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LOG2W = $clog2(WIDTH)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LOG2W-1:0] in_amt;
  logic [OP_W-1:0]  in_op;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OP_W-1:0]  out_op;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_amt,
    input  in_op,
    output in_ready,
    output out_valid,
    output out_data,
    output out_op,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    output in_amt,
    output in_op,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_op,
    output out_ready
  );

endinterface

// File: rtl/barrel_stage.sv
// barrel_stage: one pipeline level, shifting by SHIFT
// when its amount bit is set, with elastic hold.
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1,
  parameter int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_amt,
  input  logic [OP_W-1:0]  in_op,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [LOG2W-1:0] out_amt,
  output logic [OP_W-1:0]  out_op,
  input  logic             out_ready
);

  localparam int K = $clog2(SHIFT);
  localparam logic [LOG2W-1:0] BIT = LOG2W'(SHIFT);

  op_e              op_k;
  logic             hit;
  logic             rot;
  logic             right;
  logic             arith;
  logic [WIDTH-1:0] shifted;

  // Codes 5..7 all behave as pass-through.
  assign op_k  = (in_op >= OP_W'(OP_PASS)) ? OP_PASS
                                           : op_e'(in_op);
  assign hit   = in_amt[K] && (op_k != OP_PASS);
  assign rot   = (op_k == OP_ROL) || (op_k == OP_ROR);
  assign right = is_right(op_k);
  assign arith = (op_k == OP_SRA);

  assign in_ready = !out_valid || out_ready;

  // One level of shift/rotate selected by mode.
  always_comb begin
    shifted = in_data;
    unique case (1'b1)
      !hit:
        shifted = in_data;
      hit && rot && right:
        shifted = (in_data >> SHIFT)
                | (in_data << (WIDTH - SHIFT));
      hit && rot && !right:
        shifted = (in_data << SHIFT)
                | (in_data >> (WIDTH - SHIFT));
      hit && arith:
        shifted = WIDTH'($signed(in_data) >>> SHIFT);
      hit && right && !rot && !arith:
        shifted = in_data >> SHIFT;
      hit && !right && !rot:
        shifted = in_data << SHIFT;
      default:
        shifted = in_data;
    endcase
  end

  // Stage register: load when empty or draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_amt   <= '0;
      out_op    <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      out_data  <= shifted;
      out_amt   <= in_amt & ~BIT;
      out_op    <= in_op;
    end
  end

endmodule

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: LOG2W-deep elastic pipeline of
// barrel_stage levels, LSB of the amount first.
module barrel_shift_pipe
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LOG2W = $clog2(WIDTH)
) (
  input logic                clk,
  input logic                rst,
  barrel_shift_pipe_if.slave bus
);

  logic             v_s [0:LOG2W];
  logic             r_s [0:LOG2W];
  logic [WIDTH-1:0] d_s [0:LOG2W];
  logic [LOG2W-1:0] a_s [0:LOG2W];
  logic [OP_W-1:0]  o_s [0:LOG2W];

  assign v_s[0]     = bus.in_valid;
  assign d_s[0]     = bus.in_data;
  assign a_s[0]     = bus.in_amt;
  assign o_s[0]     = bus.in_op;
  assign r_s[LOG2W] = bus.out_ready;

  assign bus.in_ready  = r_s[0];
  assign bus.out_valid = v_s[LOG2W];
  assign bus.out_data  = d_s[LOG2W];
  assign bus.out_op    = o_s[LOG2W];

  for (genvar k = 0; k < LOG2W; k++) begin : g_stage
    barrel_stage #(
      .WIDTH(WIDTH),
      .SHIFT(1 << k),
      .LOG2W(LOG2W)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (v_s[k]),
      .in_data  (d_s[k]),
      .in_amt   (a_s[k]),
      .in_op    (o_s[k]),
      .in_ready (r_s[k]),
      .out_valid(v_s[k+1]),
      .out_data (d_s[k+1]),
      .out_amt  (a_s[k+1]),
      .out_op   (o_s[k+1]),
      .out_ready(r_s[k+1])
    );
  end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb_barrel_shift_pipe: directed and randomised-ready
// checks of barrel_shift_pipe against a bit-level model.
module tb_barrel_shift_pipe;

  localparam int W  = 8;
  localparam int LW = 3;

  typedef struct {
    logic [W-1:0] d;
    logic [2:0]   op;
  } exp_t;

  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int out_count = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int last_wait = 0;
  exp_t exp_q[$];

  barrel_shift_pipe_if #(.WIDTH(W)) bus ();

  barrel_shift_pipe #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Result of shifting d by amt, bit by bit.
  function automatic logic [W-1:0] model(
    input logic [W-1:0] d, input int amt, input int op);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      case (op)
        0: r[i] = (i >= amt) ? d[i-amt] : 1'b0;
        1: r[i] = (i + amt < W) ? d[i+amt] : 1'b0;
        2: r[i] = (i + amt < W) ? d[i+amt] : d[W-1];
        3: r[i] = d[(i - amt + W) % W];
        4: r[i] = d[(i + amt) % W];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Scoreboard: record accepted inputs, compare outputs.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out got=%h exp=none",
                   bus.out_data);
        end else if (bus.out_data !== exp_q[0].d ||
                     bus.out_op !== exp_q[0].op) begin
          failures++;
          $display("FAIL stream got=%h/%0d exp=%h/%0d",
                   bus.out_data, bus.out_op,
                   exp_q[0].d, exp_q[0].op);
        end
        if (bus.out_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          out_count++;
          if (out_count == 1) first_cyc = cyc;
          last_cyc = cyc;
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back('{model(bus.in_data,
                                int'(bus.in_amt),
                                int'(bus.in_op)),
                          bus.in_op});
    end
  end

  // Present one input; return after its accepting edge.
  task automatic send(input logic [W-1:0] d,
                      input int amt, input int op);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = LW'(amt);
    bus.in_op    = 3'(op);
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 200);
    last_wait = n;
    if (!bus.in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 300)
    begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [W-1:0] held;
  logic         rnd_done;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
    step(2);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_op", 32'(bus.out_op), 0);
    rst = 1'b0;
    step(1);
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    // Model pinned by hand-computed values.
    chk("model_sll", 32'(model(8'h96, 2, 0)), 32'h58);
    chk("model_srl", 32'(model(8'h96, 2, 1)), 32'h25);
    chk("model_sra", 32'(model(8'h96, 2, 2)), 32'hE5);
    chk("model_rol", 32'(model(8'h96, 2, 3)), 32'h5A);
    chk("model_ror", 32'(model(8'h96, 2, 4)), 32'hA5);
    chk("model_pass", 32'(model(8'h96, 2, 6)), 32'h96);
    chk("model_b5", 32'(model(8'hB5, 3, 0)), 32'hA8);

    // Latency: visible after the third edge,
    // counting the accepting edge.
    bus.out_ready = 1'b1;
    send(8'hB5, 3, 0);
    chk("lat1_valid", 32'(bus.out_valid), 0);
    chk("lat1_data", 32'(bus.out_data), 0);
    step(1);
    chk("lat2_valid", 32'(bus.out_valid), 0);
    chk("lat2_data", 32'(bus.out_data), 0);
    step(1);
    chk("lat3_valid", 32'(bus.out_valid), 1);
    chk("lat3_data", 32'(bus.out_data), 32'hA8);
    chk("lat3_op", 32'(bus.out_op), 0);
    wait_empty("lat_drain");

    // All modes on one operand, including amount 0.
    for (int op = 0; op < 8; op++) send(8'h96, 2, op);
    for (int op = 0; op < 5; op++) send(8'h3C, 0, op);
    wait_empty("modes_drain");

    // Back-to-back stream with no output stall.
    out_count = 0;
    for (int i = 0; i < 16; i++)
      send(W'(i * 37 + 5), i % 8, i % 6);
    wait_empty("stream_drain");
    chk("stream_count", 32'(out_count), 16);
    chk("stream_gapless", 32'(last_cyc - first_cyc), 15);

    // Bubble collapse behind a stalled output.
    bus.out_ready = 1'b0;
    send(8'hC3, 1, 2);
    step(3);
    chk("bub_out_valid", 32'(bus.out_valid), 1);
    chk("bub_rdy1", 32'(bus.in_ready), 1);
    send(8'h81, 5, 3);
    chk("bub_wait1", 32'(last_wait), 1);
    chk("bub_rdy2", 32'(bus.in_ready), 1);
    send(8'h7E, 7, 4);
    chk("bub_wait2", 32'(last_wait), 1);
    chk("full_in_ready", 32'(bus.in_ready), 0);
    held = bus.out_data;
    step(3);
    chk("full_in_ready_hold", 32'(bus.in_ready), 0);
    chk("full_data_stable", 32'(bus.out_data), 32'(held));
    chk("full_data_value", 32'(held),
        32'(model(8'hC3, 1, 2)));
    out_count = 0;
    bus.out_ready = 1'b1;
    wait_empty("bp_drain");
    chk("bp_count", 32'(out_count), 3);

    // Random backpressure against the scoreboard.
    out_count = 0;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send(W'($urandom), $urandom_range(0, 7),
               $urandom_range(0, 7));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_empty("rnd_drain");
    chk("rnd_count", 32'(out_count), 40);

    // Reset with three transactions in flight.
    bus.out_ready = 1'b0;
    send(8'h11, 1, 0);
    send(8'h22, 2, 1);
    send(8'h33, 3, 3);
    chk("flight_full", 32'(bus.in_ready), 0);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    bus.in_amt   = 3'd1;
    bus.in_op    = 3'd0;
    step(1);
    chk("rst_mid_valid", 32'(bus.out_valid), 0);
    chk("rst_mid_data", 32'(bus.out_data), 0);
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("rst_mid_ready", 32'(bus.in_ready), 1);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("rst_no_stale", 32'(bus.out_valid), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
